// File: rtl/ob_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ob_pkg
// Brief    : Shared types and sizing for the output-buffer writer/controller.
// Revision : 1.0 - initial release
// ============================================================================
package ob_pkg;

    localparam int OB_NUM_BANKS  = 8;
    localparam int OB_BANK_DEPTH = 512;
    localparam int OB_DATA_W     = 128;
    localparam int OB_ADDR_W     = 12;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        FILL   = 2'd1,
        PAD    = 2'd2,
        COMMIT = 2'd3
    } ob_wr_state_e;

    typedef logic [$clog2(OB_NUM_BANKS)-1:0] ob_bank_t;

endpackage
`default_nettype wire

// File: rtl/ob_bank_tracker.sv
`default_nettype none
// ============================================================================
// Module   : ob_bank_tracker
// Brief    : Per-bank "holds data" flags, set by the writer on commit and
//            cleared by the controller's drain-done pulses; sticky error flag
//            for pulses that do not match a full bank.
// Revision : 1.0 - initial release
// ============================================================================
module ob_bank_tracker
    import ob_pkg::*;
#(
    parameter int NUM_BANKS = OB_NUM_BANKS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_BANKS-1:0] set_vec,
    input  logic [NUM_BANKS-1:0] ram_valid,
    output logic [NUM_BANKS-1:0] data_valid,
    output logic                 proto_err
);

    // A drain pulse is illegal if the bank was not full, or if it coincides
    // with that bank's commit (in which case the commit wins).
    logic bad_pulse;
    assign bad_pulse = |(ram_valid & (~data_valid | set_vec));

    // Flag vector update: all clears processed in parallel, sets override.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_valid <= '0;
            proto_err  <= 1'b0;
        end else begin
            data_valid <= (data_valid & ~ram_valid) | set_vec;
            if (bad_pulse) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ob_bank_writer.sv
`default_nettype none
// ============================================================================
// Module   : ob_bank_writer
// Brief    : Streams result words into a banked output RAM, filling banks
//            round-robin, zero-padding short jobs and handing full banks to
//            the drain controller via DataValid/RamValid.
// Revision : 1.0 - initial release
// ============================================================================
module ob_bank_writer
    import ob_pkg::*;
#(
    parameter int NUM_BANKS  = OB_NUM_BANKS,
    parameter int BANK_DEPTH = OB_BANK_DEPTH,
    parameter int DATA_W     = OB_DATA_W,
    parameter int ADDR_W     = OB_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_W-1:0]    InData,
    input  logic                 InValid,
    input  logic                 InLast,
    output logic                 InReady,
    output logic                 WrEn,
    output logic [ADDR_W-1:0]    WrAddr,
    output logic [DATA_W-1:0]    WrData,
    output logic [NUM_BANKS-1:0] DataValid,
    input  logic [NUM_BANKS-1:0] RamValid,
    output logic                 ProtoErr
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int OFF_W  = $clog2(BANK_DEPTH);

    localparam logic [OFF_W-1:0]     OFF_LAST     = OFF_W'(BANK_DEPTH - 1);
    localparam logic [OFF_W-1:0]     OFF_ONE      = OFF_W'(1);
    localparam logic [BANK_W-1:0]    BANK_ONE     = BANK_W'(1);
    localparam logic [NUM_BANKS-1:0] BANK_ONE_HOT = NUM_BANKS'(1);

    // Address is a plain {bank, offset} concatenation, so the sizes must tile
    // the address space exactly.
    generate
        if ((NUM_BANKS * BANK_DEPTH != 2**ADDR_W) || ((1 << OFF_W) != BANK_DEPTH)) begin : g_cfg_check
            $error("ob_bank_writer: NUM_BANKS*BANK_DEPTH must equal 2**ADDR_W, BANK_DEPTH power of two");
        end
    endgenerate

    ob_wr_state_e            state;
    logic [BANK_W-1:0]       cur_bank;
    logic [OFF_W-1:0]        offset;
    logic                    accept;
    logic [NUM_BANKS-1:0]    set_vec;

    // Ready depends only on state so upstream never sees a valid->ready path.
    assign InReady = (state == FILL);
    assign accept  = InValid & InReady;
    assign set_vec = (state == COMMIT) ? (BANK_ONE_HOT << cur_bank) : '0;

    // Fill FSM with registered RAM write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= WAIT;
            cur_bank <= '0;
            offset   <= '0;
            WrEn     <= 1'b0;
            WrAddr   <= '0;
            WrData   <= '0;
        end else begin
            WrEn <= 1'b0;
            case (state)
                WAIT: begin
                    // Bank must have been drained before it is refilled.
                    if (!DataValid[cur_bank]) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        WrEn   <= 1'b1;
                        WrAddr <= {cur_bank, offset};
                        WrData <= InData;
                        if (offset == OFF_LAST) begin
                            state <= COMMIT;
                        end else begin
                            offset <= offset + OFF_ONE;
                            if (InLast) begin
                                state <= PAD;
                            end
                        end
                    end
                end
                PAD: begin
                    WrEn   <= 1'b1;
                    WrAddr <= {cur_bank, offset};
                    WrData <= '0;
                    if (offset == OFF_LAST) begin
                        state <= COMMIT;
                    end else begin
                        offset <= offset + OFF_ONE;
                    end
                end
                COMMIT: begin
                    cur_bank <= cur_bank + BANK_ONE;
                    offset   <= '0;
                    state    <= WAIT;
                end
                default: begin
                    state <= WAIT;
                end
            endcase
        end
    end

    ob_bank_tracker #(
        .NUM_BANKS (NUM_BANKS)
    ) u_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_vec    (set_vec),
        .ram_valid  (RamValid),
        .data_valid (DataValid),
        .proto_err  (ProtoErr)
    );

endmodule
`default_nettype wire

// File: tb/tb_ob_bank_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ob_bank_writer
// Brief    : Directed self-checking bench for ob_bank_writer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ob_bank_writer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] InData;
    logic         InValid;
    logic         InLast;
    logic         InReady;
    logic         WrEn;
    logic [11:0]  WrAddr;
    logic [127:0] WrData;
    logic [7:0]   DataValid;
    logic [7:0]   RamValid;
    logic         ProtoErr;

    int checks   = 0;
    int failures = 0;
    int bad_wr   = 0;

    logic [127:0] ram     [0:4095];
    logic [127:0] exp_ram [0:4095];

    ob_bank_writer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .InData    (InData),
        .InValid   (InValid),
        .InLast    (InLast),
        .InReady   (InReady),
        .WrEn      (WrEn),
        .WrAddr    (WrAddr),
        .WrData    (WrData),
        .DataValid (DataValid),
        .RamValid  (RamValid),
        .ProtoErr  (ProtoErr)
    );

    always #5 clk = ~clk;

    // RAM model and write-to-full-bank monitor.
    always @(posedge clk) begin
        if (WrEn) begin
            ram[WrAddr] <= WrData;
            if (DataValid[WrAddr[11:9]]) bad_wr <= bad_wr + 1;
        end
    end

    function automatic logic [127:0] word(input int i);
        logic [31:0] u;
        u = i;
        return {u, 32'hC0DE_0000 ^ u, u * 32'd7, 32'h0F0F_F0F0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one word, wait for ready, and check the registered write.
    task automatic send_word(input logic [127:0] d, input logic last, input int exp_addr);
        int n;
        InValid = 1'b1;
        InData  = d;
        InLast  = last;
        n = 0;
        while (!InReady && n < 2000) begin
            tick();
            n++;
        end
        if (!InReady) begin
            chk("ready_timeout", 160'(InReady), 160'(1));
        end else begin
            tick();
            chk("write", {WrEn, WrAddr, WrData}, {1'b1, 12'(exp_addr), d});
        end
        InValid = 1'b0;
        InLast  = 1'b0;
    endtask

    initial begin
        int errs;
        int mb, mo, seq, drained, mism, base;
        logic [7:0] sched;
        int cnt [8];

        rst_n    = 1'b0;
        InData   = '0;
        InValid  = 1'b0;
        InLast   = 1'b0;
        RamValid = '0;
        repeat (3) tick();
        chk("reset_outputs", {InReady, WrEn, WrAddr, WrData, DataValid, ProtoErr}, '0);
        rst_n = 1'b1;
        chk("ready_wait_after_reset", 160'(InReady), 160'(0));

        // One full bank, back-to-back.
        for (int i = 0; i < 512; i++) send_word(word(i), 1'b0, i);
        chk("dv_before_commit", 160'(DataValid), 160'(0));
        tick();
        chk("dv_bank0_set", {WrEn, DataValid}, {1'b0, 8'h01});

        // Fill every remaining bank without draining.
        for (int i = 512; i < 4096; i++) send_word(word(i), 1'b0, i);
        tick();
        chk("dv_all_set", 160'(DataValid), 160'(8'hFF));
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (InReady !== 1'b0) errs++;
        end
        chk("ready_held_low_when_full", 160'(errs), 160'(0));
        RamValid = 8'h01;
        tick();
        RamValid = 8'h00;
        chk("dv_bank0_cleared", {InReady, DataValid}, {1'b0, 8'hFE});
        tick();
        chk("ready_after_drain", 160'(InReady), 160'(1));
        send_word(word(4096), 1'b0, 0);
        chk("ram_word1", 160'(ram[1]), 160'(word(1)));
        chk("ram_word4095", 160'(ram[4095]), 160'(word(4095)));
        chk("no_proto_err", 160'(ProtoErr), 160'(0));

        // Short job: 3 words then zero padding.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("reset2_outputs", {InReady, WrEn, WrAddr, WrData, DataValid, ProtoErr}, '0);
        send_word(word(10000), 1'b0, 0);
        send_word(word(10001), 1'b0, 1);
        send_word(word(10002), 1'b1, 2);
        errs = 0;
        for (int k = 3; k < 512; k++) begin
            tick();
            if (!(WrEn === 1'b1 && WrAddr === 12'(k) && WrData === 128'd0 && InReady === 1'b0)) errs++;
        end
        chk("pad_sequence", 160'(errs), 160'(0));
        tick();
        chk("dv_after_pad", {WrEn, DataValid}, {1'b0, 8'h01});
        chk("ram_pad_data1", 160'(ram[1]), 160'(word(10001)));
        chk("ram_pad_zero3", 160'(ram[3]), 160'(0));
        chk("ram_pad_zero511", 160'(ram[511]), 160'(0));

        // Single-word job (InLast at offset 0) in the next bank.
        send_word(word(20000), 1'b1, 512);
        errs = 0;
        while (DataValid !== 8'h03 && errs < 600) begin
            tick();
            errs++;
        end
        chk("dv_two_banks", 160'(DataValid), 160'(8'h03));
        chk("ram_last_at_0_pad", 160'(ram[1023]), 160'(0));
        chk("proto_clean", 160'(ProtoErr), 160'(0));

        // Drain pulse for an empty bank.
        RamValid = 8'h04;
        tick();
        RamValid = 8'h00;
        chk("proto_dv_unchanged", {ProtoErr, DataValid}, {1'b1, 8'h03});
        repeat (3) tick();
        chk("proto_sticky", 160'(ProtoErr), 160'(1));
        RamValid = 8'h01;
        tick();
        RamValid = 8'h00;
        chk("legal_drain_after_err", {ProtoErr, DataValid}, {1'b1, 8'h02});

        // Reset in the middle of bank 2.
        for (int i = 0; i < 100; i++) send_word(word(30000 + i), 1'b0, 1024 + i);
        InValid = 1'b1;
        InData  = word(39999);
        rst_n   = 1'b0;
        tick();
        chk("reset_midfill", {InReady, WrEn, WrAddr, WrData, DataValid, ProtoErr}, '0);
        rst_n   = 1'b1;
        InValid = 1'b0;
        send_word(word(30500), 1'b0, 0);

        // Random valid gaps and drain latency against a reference model.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bad_wr  = 0;
        mb = 0; mo = 0; seq = 0; drained = 0;
        sched = '0;
        for (int b = 0; b < 8; b++) cnt[b] = 0;
        for (int cyc = 0; cyc < 60000 && drained < 16; cyc++) begin
            RamValid = '0;
            for (int b = 0; b < 8; b++) begin
                if (sched[b]) begin
                    if (cnt[b] == 0) begin
                        mism = 0;
                        base = b * 512;
                        for (int k = 0; k < 512; k++)
                            if (ram[base + k] !== exp_ram[base + k]) mism++;
                        chk("drain_bank_contents", 160'(mism), 160'(0));
                        RamValid[b] = 1'b1;
                        sched[b]    = 1'b0;
                        drained++;
                    end else begin
                        cnt[b]--;
                    end
                end else if (DataValid[b]) begin
                    sched[b] = 1'b1;
                    cnt[b]   = $urandom_range(0, 25);
                end
            end
            InValid = ($urandom_range(0, 3) != 0);
            InData  = word(50000 + seq);
            InLast  = ($urandom_range(0, 399) == 0);
            if (InValid && InReady) begin
                exp_ram[mb * 512 + mo] = InData;
                seq++;
                if (InLast || mo == 511) begin
                    for (int k = mo + 1; k < 512; k++) exp_ram[mb * 512 + k] = '0;
                    mb = (mb + 1) % 8;
                    mo = 0;
                end else begin
                    mo++;
                end
            end
            tick();
        end
        InValid  = 1'b0;
        InLast   = 1'b0;
        RamValid = '0;
        chk("random_drained_count", 160'(drained), 160'(16));
        chk("no_write_to_full_bank", 160'(bad_wr), 160'(0));
        chk("random_no_proto_err", 160'(ProtoErr), 160'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
